// File: rtl/wl_scan_brick_if.sv
// Handshake bundle between a brick compare, wl_scan_brick and the wordline encoder.
// The slave modport is the scanner's view; the master modport is the surrounding logic's view.
interface wl_scan_brick_if #(
  parameter int WL_WIDTH  = 32,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WL_WIDTH-1:0]  in_match;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WL_WIDTH-1:0]  out_wls;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_last;
  logic                 drop_zero;

  modport master (
    output in_valid, in_match, in_tag, out_ready,
    input  in_ready, out_valid, out_wls, out_tag, out_last, drop_zero
  );

  modport slave (
    input  in_valid, in_match, in_tag, out_ready,
    output in_ready, out_valid, out_wls, out_tag, out_last, drop_zero
  );
endinterface

// File: rtl/wl_scan_brick.sv
// Splits a multi-hot match vector into one-hot wordline beats, lowest index first,
// so the downstream encoder only ever sees legal one-hot inputs.
module wl_scan_brick #(
  parameter int WL_WIDTH  = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  wl_scan_brick_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state, state_nxt;
  logic [WL_WIDTH-1:0]  pend;
  logic [WL_WIDTH-1:0]  pend_low;
  logic [WL_WIDTH-1:0]  pend_rest;
  logic [TAG_WIDTH-1:0] tag_r;
  logic                 drop_r;
  logic                 accept;
  logic                 nonzero;
  logic                 beat_hs;
  logic                 is_last;

  // Bit-parallel isolation: lowest set bit, and the vector with that bit cleared.
  assign pend_low  = pend & (~pend + WL_WIDTH'(1));
  assign pend_rest = pend & (pend - WL_WIDTH'(1));
  assign is_last   = (pend_rest == '0);
  assign nonzero   = |bus.in_match;
  assign beat_hs   = (state == SCAN) && bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order across always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && nonzero) state_nxt = SCAN;
      SCAN:    if (beat_hs && is_last) state_nxt = (accept && nonzero) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new vector may only load on the last-beat handshake, so pend never mixes vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      tag_r  <= '0;
      drop_r <= 1'b0;
    end else begin
      drop_r <= accept && !nonzero;
      if (accept && nonzero) begin
        pend  <= bus.in_match;
        tag_r <= bus.in_tag;
      end else if (beat_hs) begin
        pend  <= pend_rest;
      end
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_wls   = '0;
    bus.out_last  = 1'b0;
    bus.out_tag   = tag_r;
    bus.drop_zero = drop_r;
    if (!rst) bus.in_ready = (state == IDLE) || (beat_hs && is_last);
    if (state == SCAN) begin
      bus.out_valid = 1'b1;
      bus.out_wls   = pend_low;
      bus.out_last  = is_last;
    end
  end
endmodule

// File: tb/tb_wl_scan_brick.sv
// Bench for wl_scan_brick: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-of-beats reference model.
module tb_wl_scan_brick;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wl_scan_brick_if #(.WL_WIDTH(32), .TAG_WIDTH(8)) bus ();

  wl_scan_brick #(.WL_WIDTH(32), .TAG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        iv;
    logic [31:0] m;
    logic [7:0]  tag;
    logic        ordy;
    logic        ev;
    logic [31:0] ewls;
    logic [7:0]  etag;
    logic        elast;
    logic        erdy;
    logic        edrop;
  } vec_t;

  typedef struct {
    logic [31:0] wls;
    logic [7:0]  tag;
    logic        last;
  } beat_t;

  vec_t  tbl [21];
  beat_t q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle and settle before the caller samples outputs.
  task automatic apply(input logic iv, input logic [31:0] m, input logic [7:0] tag,
                       input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_match  = m;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic check_beat(input string name, input logic [31:0] wls, input logic [7:0] tag,
                            input logic last);
    check({name, " valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " wls"},   bus.out_wls, wls);
    check({name, " tag"},   32'(bus.out_tag), 32'(tag));
    check({name, " last"},  32'(bus.out_last), 32'(last));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m;
    logic [7:0]  tg;
    logic [7:0]  last_tag;
    logic        exp_valid, exp_rdy, exp_drop, hs, acc;
    int          r;
    beat_t       b;

    tbl[0]  = '{1'b1, 32'h0000_0005, 8'hA1, 1'b1, 1'b0, 32'h0,         8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 32'h1,         8'hA1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 32'h4,         8'hA1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0,         8'hA1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h8000_0001, 8'hB2, 1'b0, 1'b0, 32'h0,         8'hA1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0007, 8'hEE, 1'b0, 1'b1, 32'h1,         8'hB2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0007, 8'hEE, 1'b0, 1'b1, 32'h1,         8'hB2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0007, 8'hEE, 1'b0, 1'b1, 32'h1,         8'hB2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0007, 8'hEE, 1'b1, 1'b1, 32'h1,         8'hB2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 32'h8000_0000, 8'hB2, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0002, 8'h01, 1'b1, 1'b0, 32'h0,         8'hB2, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0300, 8'h02, 1'b1, 1'b1, 32'h2,         8'h01, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 32'h100,       8'h02, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 32'h200,       8'h02, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 32'h0,         8'h33, 1'b1, 1'b0, 32'h0,         8'h02, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0,         8'h02, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0,         8'h02, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 32'h0000_0010, 8'h44, 1'b1, 1'b0, 32'h0,         8'h02, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 32'h0,         8'h55, 1'b1, 1'b1, 32'h10,        8'h44, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0,         8'h44, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0,         8'h44, 1'b0, 1'b1, 1'b0};

    // Reset state
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_match  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst in_ready",  32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_wls",   bus.out_wls, 32'd0);
    check("rst out_tag",   32'(bus.out_tag), 32'd0);
    check("rst out_last",  32'(bus.out_last), 32'd0);
    check("rst drop_zero", 32'(bus.drop_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table: single vector, backpressure, back-to-back, zero vectors
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].iv, tbl[i].m, tbl[i].tag, tbl[i].ordy);
      check($sformatf("tbl%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d out_wls", i),   bus.out_wls, tbl[i].ewls);
      check($sformatf("tbl%0d out_tag", i),   32'(bus.out_tag), 32'(tbl[i].etag));
      check($sformatf("tbl%0d out_last", i),  32'(bus.out_last), 32'(tbl[i].elast));
      check($sformatf("tbl%0d in_ready", i),  32'(bus.in_ready), 32'(tbl[i].erdy));
      check($sformatf("tbl%0d drop_zero", i), 32'(bus.drop_zero), 32'(tbl[i].edrop));
    end

    // Full vector: 32 beats, last only on the final one
    apply(1'b1, 32'hFFFF_FFFF, 8'h5A, 1'b1);
    check("full accept in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 32'h0, 8'h00, 1'b1);
      check_beat($sformatf("full beat%0d", i), 32'd1 << i, 8'h5A, (i == 31));
    end
    apply(1'b0, 32'h0, 8'h00, 1'b1);
    check("full done out_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-scan aborts the vector, then a fresh vector scans normally
    apply(1'b1, 32'h0000_00F0, 8'h77, 1'b1);
    apply(1'b0, 32'h0, 8'h00, 1'b1);
    check_beat("mid beat0", 32'h10, 8'h77, 1'b0);
    apply(1'b0, 32'h0, 8'h00, 1'b1);
    check_beat("mid beat1", 32'h20, 8'h77, 1'b0);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_match  = 32'hFF;
    #1;
    check("mid rst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid rst out_wls",   bus.out_wls, 32'd0);
    check("mid rst out_tag",   32'(bus.out_tag), 32'd0);
    check("mid rst out_last",  32'(bus.out_last), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid post-rst in_ready",  32'(bus.in_ready), 32'd1);
    check("mid post-rst out_valid", 32'(bus.out_valid), 32'd0);
    apply(1'b1, 32'h0000_0009, 8'h12, 1'b1);
    apply(1'b0, 32'h0, 8'h00, 1'b1);
    check_beat("fresh beat0", 32'h1, 8'h12, 1'b0);
    apply(1'b0, 32'h0, 8'h00, 1'b1);
    check_beat("fresh beat1", 32'h8, 8'h12, 1'b1);

    // Randomized traffic against a queue-of-beats model
    q.delete();
    last_tag = 8'h12;
    exp_drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 7);
      if (r == 0)     m = 32'h0;
      else if (r < 4) m = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
      else            m = $urandom;
      tg = 8'($urandom);
      apply(($urandom_range(0, 3) != 0), m, tg, ($urandom_range(0, 3) != 0));

      exp_valid = (q.size() != 0);
      exp_rdy   = (q.size() == 0) || ((q.size() == 1) && bus.out_ready);
      check("rnd out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("rnd out_wls",  bus.out_wls, q[0].wls);
        check("rnd out_tag",  32'(bus.out_tag), 32'(q[0].tag));
        check("rnd out_last", 32'(bus.out_last), 32'(q[0].last));
      end else begin
        check("rnd idle out_wls", bus.out_wls, 32'd0);
        check("rnd idle out_tag", 32'(bus.out_tag), 32'(last_tag));
      end
      check("rnd in_ready",  32'(bus.in_ready), 32'(exp_rdy));
      check("rnd drop_zero", 32'(bus.drop_zero), 32'(exp_drop));

      hs  = exp_valid && bus.out_ready;
      acc = bus.in_valid && exp_rdy;
      if (hs) void'(q.pop_front());
      exp_drop = acc && (m == 32'h0);
      if (acc && (m != 32'h0)) begin
        last_tag = tg;
        for (int k = 0; k < 32; k++) begin
          if (m[k]) begin
            b.wls  = 32'd1 << k;
            b.tag  = tg;
            b.last = 1'b0;
            q.push_back(b);
          end
        end
        q[q.size() - 1].last = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
